// File: rtl/definitions.sv
// rtl/definitions.sv - shared core types: register names and hazard controller states
package definitions;

    typedef logic [4:0] regName_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - 32-bit saturating event counter with synchronous active-low clear
module sat_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - stall/flush controller for the 5-stage pipeline; optional HAZARD_PERF_EN counters
module hazard_control
    import definitions::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rstN,
    input  regName_t  id_rs1,
    input  regName_t  id_rs2,
    input  logic      id_use_rs1,
    input  logic      id_use_rs2,
    input  regName_t  ex_rd,
    input  logic      ex_memRead,
    input  logic      ex_branch_taken,
    input  logic      mem_req,
    input  logic      mem_ready,
    output logic      pc_en,
    output logic      ifid_en,
    output logic      idex_en,
    output logic      exmem_en,
    output logic      ifid_flush,
    output logic      idex_flush,
    output logic      memwb_bubble,
    output logic      hz_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t state, state_next;
    logic [CW-1:0] wait_cnt, wait_next;
    logic          mem_stall;
    logic          lu_hazard;
    logic          branch_flush;

    assign mem_stall = mem_req & ~mem_ready;
    assign lu_hazard = ex_memRead & (ex_rd != '0) &
                       ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // wait_cnt holds the number of stalled cycles already completed in this access
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    wait_next  = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        state_next = ERROR;
                    end else begin
                        wait_next = wait_cnt + CW'(1);
                    end
                end else begin
                    state_next = RUN;
                    wait_next  = '0;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        hz_error     = 1'b0;
        branch_flush = 1'b0;
        if (!rstN) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state == ERROR) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            hz_error = 1'b1;
        end else if (mem_stall) begin
            // frozen stages re-present any branch or load-use once memory completes
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    sat_counter u_stall_cnt (
        .clk    (clk),
        .resetn (rstN),
        .en     (~pc_en & (state != ERROR)),
        .count  (stall_cnt)
    );

    sat_counter u_flush_cnt (
        .clk    (clk),
        .resetn (rstN),
        .en     (branch_flush),
        .count  (flush_cnt)
    );
`endif

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard controller for the 5-stage RISC-V core: the stall/flush counterpart to the EX-stage operand forwarding unit. It detects the hazards forwarding cannot resolve: load-use in ID, taken branch/jump in EX, and a data-memory access in MEM that is not yet ready. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A state machine tracks multi-cycle memory waits and raises a sticky error on timeout.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 16: stalled memory cycles before error; legal range ≥ 2.

Ports:
- `clk`: input, 1 bit, core clock.
- `rstN`: input, 1 bit, reset, synchronous, active-low.
- `id_rs1`, `id_rs2`: input, `regName_t`, source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`: input, 1 bit each, ID instruction actually reads rs1/rs2.
- `ex_rd`: input, `regName_t`, destination of the instruction in EX.
- `ex_memRead`: input, 1 bit, EX instruction is a load.
- `ex_branch_taken`: input, 1 bit, EX resolved a taken branch/jump.
- `mem_req`: input, 1 bit, MEM instruction is accessing data memory.
- `mem_ready`: input, 1 bit, data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`: output, 1 bit each, register load enables.
- `ifid_flush`, `idex_flush`: output, 1 bit each, load a bubble (NOP, regWrite=0).
- `memwb_bubble`: output, 1 bit, MEM/WB loads a bubble instead of the MEM result.
- `hz_error`: output, 1 bit, sticky memory-timeout error.
- `stall_cnt`, `flush_cnt`: output, 32 bits each, present only with `HAZARD_PERF_EN`.

## Operation

State machine with states RUN, MEM_WAIT and ERROR. The state resets to RUN, and `wait_cnt` (width `$clog2(MEM_TIMEOUT+1)`) resets to 0.

Signal definitions:
- `mem_stall` = `mem_req & ~mem_ready`
- `lu_hazard` = `ex_memRead & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2))`

Transitions:
- RUN → MEM_WAIT on `mem_stall`; `wait_cnt` ← 1.
- MEM_WAIT → RUN on `mem_ready`; `wait_cnt` ← 0.
- MEM_WAIT with `mem_stall`:
  - if `wait_cnt == MEM_TIMEOUT-1`, go to ERROR;
  - else increment `wait_cnt`.
- ERROR is terminal until `rstN` is low.

Outputs are combinational from state and inputs, in this priority order:
1. **ERROR**: all enables 0, all flushes/bubble 0, `hz_error` = 1.
2. **`mem_stall`** (RUN or MEM_WAIT): `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0; `memwb_bubble` = 1. Branch and load-use are ignored this cycle; the frozen stages re-present them later.
3. **`ex_branch_taken`**: all enables 1, `ifid_flush` = 1, `idex_flush` = 1. Any load-use is discarded because the ID instruction is squashed.
4. **`lu_hazard`**: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1; `idex_en` and `exmem_en` stay 1. This inserts exactly one bubble; the next cycle the load is in MEM and forwarding handles it.
5. **Otherwise**: all enables 1, all flushes/bubble 0.

A flush takes precedence over an enable at the target register.

## Timing

- **While `rstN` is low:** enables are 0; `ifid_flush`, `idex_flush` and `memwb_bubble` are 1; `hz_error` is 0. From the first edge with `rstN` high, the state is RUN.
- **Detection latency:** zero cycles. Hazards are flagged in the same cycle they are present, and the controls act at the next rising edge.
- **`mem_ready` response:** `mem_ready` high in stall cycle n releases the pipeline at the edge ending cycle n.
- **Timeout:** ERROR is entered at the edge ending the `MEM_TIMEOUT`-th consecutive cycle of `mem_stall`. If `mem_ready` arrives in that same cycle, the access completes and no error is raised.
- **Reset mid-wait:** returns to RUN and clears `wait_cnt` and `hz_error`.
- **Back-to-back memory stalls:** a `mem_stall` in the cycle after returning to RUN re-enters MEM_WAIT with `wait_cnt` = 1.

## Configuration

- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments in every non-ERROR cycle with `pc_en` = 0.
  - `flush_cnt` increments in every cycle where a branch flush is applied.
  - Both counters saturate at 2^32−1 and are cleared by reset.
- `HAZARD_PERF_EN` undefined: the counters and their ports are absent; the remaining behaviour is identical.

## Structure

- The shared package `definitions` holds:
  - the `hazard_state_t` enum (RUN, MEM_WAIT, ERROR);
  - the existing `regName_t`.
- Sub-module `sat_counter` (32-bit saturating counter with enable, synchronous active-low clear) is instantiated twice under `HAZARD_PERF_EN`.

## Test plan

- **Load-use:** `ex_memRead`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1; the next cycle all enables are 1.
- **x0 and unused operands:** `ex_rd`=0, or `id_use_rs1`=0 with `id_rs1` matching → no stall.
- **Branch over load-use:** `ex_branch_taken`=1 together with a load-use match → `ifid_flush`=`idex_flush`=1 and `pc_en`=1.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 3 cycles, then high → 3 frozen cycles with `memwb_bubble`=1, then release; the state returns to RUN.
- **Timeout:** `MEM_TIMEOUT`=4 with `mem_ready` held low → `hz_error`=1 after 4 cycles, enables 0 and held; `rstN` low for 1 cycle clears it.
- **Perf counters (`HAZARD_PERF_EN`):** 2 load-use stalls, 1 memory wait of 3 cycles and 1 branch → `stall_cnt`=5, `flush_cnt`=1.
